// File: rtl/ifetch_axi_master.sv
// Instruction-fetch AXI read master with a single line buffer: hits answer one
// cycle after the request, misses fetch the aligned line with one INCR burst.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module ifetch_axi_master #(
    parameter logic [`AXI_ID_BITS-1:0] MASTER_ID  = '0,
    parameter int unsigned             LINE_WORDS = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       if_req,
    input  logic [31:0]                if_addr,
    input  logic                       if_flush,
    output logic                       if_ack,
    output logic [31:0]                if_rdata,
    output logic                       if_err,
    output logic [`AXI_ID_BITS-1:0]    ARID_M,
    output logic [`AXI_ADDR_BITS-1:0]  ARADDR_M,
    output logic [`AXI_LEN_BITS-1:0]   ARLEN_M,
    output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M,
    output logic [1:0]                 ARBURST_M,
    output logic                       ARVALID_M,
    input  logic                       ARREADY_M,
    input  logic [`AXI_ID_BITS-1:0]    RID_M,
    input  logic [`AXI_DATA_BITS-1:0]  RDATA_M,
    input  logic [1:0]                 RRESP_M,
    input  logic                       RLAST_M,
    input  logic                       RVALID_M,
    output logic                       RREADY_M
);

    localparam int unsigned WB  = $clog2(LINE_WORDS);
    localparam int unsigned OFF = WB + 2;
    localparam int unsigned CW  = WB + 1;
    localparam int unsigned TW  = 32 - OFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_RD,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            line_valid_q, line_valid_d;
    logic [TW-1:0]   tag_q, tag_d;
    logic [31:0]     buf_q [LINE_WORDS];
    logic [31:0]     buf_d [LINE_WORDS];
    logic [31:0]     araddr_q, araddr_d;
    logic [WB-1:0]   widx_q, widx_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_acc_q, err_acc_d;
    logic            flush_pend_q, flush_pend_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [WB-1:0]   req_widx;
    logic [TW-1:0]   req_tag;
    logic            hit;
    logic            beat_err;
    logic            err_final;
    logic [31:0]     beat_data;
    logic            unused_addr_lsbs;

    assign req_widx         = if_addr[OFF-1:2];
    assign req_tag          = if_addr[31:OFF];
    assign hit              = line_valid_q && (tag_q == req_tag);
    assign beat_data        = 32'(RDATA_M);
    assign unused_addr_lsbs = ^if_addr[1:0];

    always_comb begin
        state_d      = state_q;
        line_valid_d = line_valid_q;
        tag_d        = tag_q;
        buf_d        = buf_q;
        araddr_d     = araddr_q;
        widx_d       = widx_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        cnt_d        = cnt_q;
        err_acc_d    = err_acc_q;
        flush_pend_d = flush_pend_q;
        ack_d        = 1'b0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        beat_err     = 1'b0;
        err_final    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (if_flush) begin
                    line_valid_d = 1'b0;
                end
                if (if_req) begin
                    // A flush in the same cycle forces the miss path.
                    if (hit && !if_flush) begin
                        rdata_d = buf_q[req_widx];
                        err_d   = 1'b0;
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        araddr_d  = {req_tag, {OFF{1'b0}}};
                        widx_d    = req_widx;
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end

            S_AR: begin
                if (if_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (ARREADY_M) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = '0;
                    err_acc_d = 1'b0;
                    state_d   = S_RD;
                end
            end

            S_RD: begin
                if (if_flush) begin
                    flush_pend_d = 1'b1;
                end
                if (RVALID_M) begin
                    beat_err = (RRESP_M != 2'b00) || (RID_M != MASTER_ID);
                    // Counter saturates at LINE_WORDS so overrun beats never overwrite the line.
                    if (cnt_q < CW'(LINE_WORDS)) begin
                        buf_d[cnt_q[WB-1:0]] = beat_data;
                        cnt_d                = cnt_q + CW'(1);
                    end else begin
                        beat_err = 1'b1;
                    end
                    if (RLAST_M) begin
                        if (cnt_q != CW'(LINE_WORDS - 1)) begin
                            beat_err = 1'b1;
                        end
                        err_final    = err_acc_q || beat_err;
                        line_valid_d = !(err_final || flush_pend_q || if_flush);
                        tag_d        = araddr_q[31:OFF];
                        rdata_d      = (cnt_q == {1'b0, widx_q}) ? beat_data : buf_q[widx_q];
                        err_d        = err_final;
                        rready_d     = 1'b0;
                        ack_d        = 1'b1;
                        state_d      = S_RESP;
                    end else begin
                        err_acc_d = err_acc_q || beat_err;
                    end
                end
            end

            S_RESP: begin
                if (if_flush) begin
                    line_valid_d = 1'b0;
                end
                flush_pend_d = 1'b0;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= S_IDLE;
            line_valid_q <= 1'b0;
            tag_q        <= '0;
            buf_q        <= '{default: '0};
            araddr_q     <= '0;
            widx_q       <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            cnt_q        <= '0;
            err_acc_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_valid_q <= line_valid_d;
            tag_q        <= tag_d;
            buf_q        <= buf_d;
            araddr_q     <= araddr_d;
            widx_q       <= widx_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            cnt_q        <= cnt_d;
            err_acc_q    <= err_acc_d;
            flush_pend_q <= flush_pend_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign if_ack    = ack_q;
    assign if_rdata  = rdata_q;
    assign if_err    = err_q;
    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = `AXI_ADDR_BITS'(araddr_q);
    assign ARLEN_M   = `AXI_LEN_BITS'(LINE_WORDS - 1);
    assign ARSIZE_M  = `AXI_SIZE_BITS'(3'b010);
    assign ARBURST_M = 2'b01;
    assign ARVALID_M = arvalid_q;
    assign RREADY_M  = rready_q;

endmodule

// File: tb/tb_ifetch_axi_master.sv
// Scoreboard bench for ifetch_axi_master: a line-cache reference model predicts
// responses and AR addresses; a behavioural AXI slave serves bursts from a memory function.
module tb_ifetch_axi_master;

    localparam int         LW  = 4;
    localparam logic [3:0] MID = 4'd3;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        flush_core = 1'b0;
    logic        flush_slave = 1'b0;
    logic        if_flush;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic [3:0]  ARID_M;
    logic [31:0] ARADDR_M;
    logic [3:0]  ARLEN_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M;
    logic        ARREADY_M = 1'b0;
    logic [3:0]  RID_M = '0;
    logic [31:0] RDATA_M = '0;
    logic [1:0]  RRESP_M = '0;
    logic        RLAST_M = 1'b0;
    logic        RVALID_M = 1'b0;
    logic        RREADY_M;

    assign if_flush = flush_core | flush_slave;

    ifetch_axi_master #(
        .MASTER_ID (MID),
        .LINE_WORDS(LW)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .ARID_M   (ARID_M),
        .ARADDR_M (ARADDR_M),
        .ARLEN_M  (ARLEN_M),
        .ARSIZE_M (ARSIZE_M),
        .ARBURST_M(ARBURST_M),
        .ARVALID_M(ARVALID_M),
        .ARREADY_M(ARREADY_M),
        .RID_M    (RID_M),
        .RDATA_M  (RDATA_M),
        .RRESP_M  (RRESP_M),
        .RLAST_M  (RLAST_M),
        .RVALID_M (RVALID_M),
        .RREADY_M (RREADY_M)
    );

    initial forever #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'h10) return 32'h11 * ({30'd0, w[3:2]} + 32'd1);
        return (w * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Scoreboard queues and burst configuration shared with the slave.
    logic [32:0] exp_q[$];
    logic [31:0] exp_ar[$];
    int cfg_ar_delay = -1, cfg_err_beat = -1, cfg_early_last = -1;
    int cfg_badid_beat = -1, cfg_flush_beat = -1;
    bit cfg_extra = 0;
    int ar_hs = 0;

    // Reference model: one line, valid flag and line address.
    bit          mv = 0;
    logic [31:0] mline = '0;

    // Behavioural AXI read slave, driven on the falling edge.
    bit          sl_active = 0, sl_flushed = 0;
    int          sl_wait = 0, sl_beat = 0, sl_last = 0;
    int          sl_err_beat = -1, sl_badid_beat = -1, sl_flush_beat = -1;
    logic [31:0] sl_line = '0;
    bit          prev_arv = 0, prev_rv = 0, prev_rr = 0;
    logic [31:0] prev_araddr = '0;
    logic [12:0] prev_fields = '0;

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            sl_active = 0; sl_beat = 0; sl_wait = 0;
            ARREADY_M = 0; RVALID_M = 0; RLAST_M = 0; RRESP_M = 0; RID_M = '0; RDATA_M = '0;
            flush_slave = 0; prev_arv = 0; prev_rv = 0; prev_rr = 0;
        end else begin
            if (prev_arv && ARREADY_M) begin
                ar_hs++;
                if (exp_ar.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ar actual=%0h required=none", prev_araddr);
                end else begin
                    chk("ar_addr", prev_araddr, exp_ar.pop_front());
                end
                chk("ar_fields", prev_fields, {MID, 4'd3, 3'd2, 2'd1});
                sl_active = 1; sl_beat = 0; sl_flushed = 0; sl_line = prev_araddr;
                sl_err_beat = cfg_err_beat; sl_badid_beat = cfg_badid_beat;
                sl_flush_beat = cfg_flush_beat;
                sl_last = (cfg_early_last >= 0) ? cfg_early_last : (cfg_extra ? LW : LW - 1);
            end else if (prev_arv) begin
                chk("ar_hold_valid", ARVALID_M, 1);
                chk("ar_hold_addr", ARADDR_M, prev_araddr);
            end
            if (prev_rv && prev_rr) begin
                if (sl_beat == sl_last) sl_active = 0;
                sl_beat++;
            end
            flush_slave = 0;
            ARREADY_M = 0;
            if (ARVALID_M && !sl_active) begin
                if (!prev_arv) sl_wait = (cfg_ar_delay >= 0) ? cfg_ar_delay : int'($urandom_range(0, 3));
                if (sl_wait == 0) ARREADY_M = 1;
                else sl_wait--;
            end
            RVALID_M = 0; RLAST_M = 0; RRESP_M = 2'b00; RID_M = MID;
            if (sl_active && RREADY_M && ($urandom_range(0, 3) != 0)) begin
                RVALID_M = 1;
                RDATA_M  = (sl_beat < LW) ? mem_word(sl_line + 32'(4 * sl_beat)) : $urandom;
                RLAST_M  = (sl_beat == sl_last);
                RRESP_M  = (sl_beat == sl_err_beat) ? 2'b10 : 2'b00;
                RID_M    = (sl_beat == sl_badid_beat) ? ~MID : MID;
                if (sl_beat == sl_flush_beat && !sl_flushed) begin
                    flush_slave = 1; sl_flushed = 1;
                end
            end
            prev_arv = ARVALID_M; prev_araddr = ARADDR_M;
            prev_fields = {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M};
            prev_rv = RVALID_M; prev_rr = RREADY_M;
        end
    end

    // Response monitor.
    bit prev_ack = 0;
    always @(negedge ACLK) begin : mon
        logic [32:0] e;
        if (ARESETn) begin
            if (if_ack) begin
                chk("ack_pulse", prev_ack, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack actual=%0h required=none", if_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", if_rdata, e[31:0]);
                    chk("err", if_err, e[32]);
                end
            end
            prev_ack = if_ack;
        end else begin
            prev_ack = 0;
        end
    end

    task automatic fetch(input logic [31:0] addr, input bit flush_same);
        logic [31:0] line;
        bit hit, merr;
        int n, ar_before;
        bit got;
        line = addr & ~32'(LW * 4 - 1);
        hit  = mv && (mline == line) && !flush_same;
        merr = (cfg_err_beat >= 0) || (cfg_early_last >= 0) || (cfg_badid_beat >= 0) || cfg_extra;
        if (!hit) exp_ar.push_back(line);
        exp_q.push_back({hit ? 1'b0 : merr, mem_word(addr)});
        ar_before = ar_hs;
        @(posedge ACLK); #1;
        if_req = 1; if_addr = addr; flush_core = flush_same;
        n = 0; got = 0;
        while (n < 200) begin
            @(posedge ACLK); #1;
            flush_core = 0;
            n++;
            if (if_ack) begin got = 1; break; end
        end
        if_req = 0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout actual=none required=ack addr=%0h", addr);
        end else if (hit) begin
            chk("hit_latency", n, 1);
            chk("hit_no_ar", ar_hs, ar_before);
        end
        if (!hit) begin
            mv = !(merr || (cfg_flush_beat >= 0));
            mline = line;
        end
        cfg_ar_delay = -1; cfg_err_beat = -1; cfg_early_last = -1;
        cfg_badid_beat = -1; cfg_flush_beat = -1; cfg_extra = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, if_ack, 0);
        chk({tag, "_rdata"}, if_rdata, 0);
        chk({tag, "_err"}, if_err, 0);
        chk({tag, "_arvalid"}, ARVALID_M, 0);
        chk({tag, "_araddr"}, ARADDR_M, 0);
        chk({tag, "_rready"}, RREADY_M, 0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_outputs("reset");
        ARESETn = 1;

        fetch(32'h0000_0004, 0);
        fetch(32'h0000_000C, 0);

        cfg_ar_delay = 5;
        fetch(32'h0000_0100, 0);
        fetch(32'h0000_0108, 0);

        cfg_err_beat = 1;
        fetch(32'h0000_0204, 0);
        fetch(32'h0000_0208, 0);

        cfg_flush_beat = 1;
        fetch(32'h0000_0300, 0);
        fetch(32'h0000_0300, 0);

        cfg_early_last = 1;
        fetch(32'h0000_0404, 0);
        fetch(32'h0000_0400, 0);

        cfg_badid_beat = 3;
        fetch(32'h0000_050C, 0);

        cfg_extra = 1;
        fetch(32'h0000_0600, 0);

        fetch(32'h0000_0700, 0);
        fetch(32'h0000_0704, 1);
        fetch(32'h0000_0708, 0);

        @(posedge ACLK); #1;
        flush_core = 1;
        @(posedge ACLK); #1;
        flush_core = 0;
        mv = 0;
        fetch(32'h0000_070C, 0);

        exp_ar.push_back(32'h0000_0800);
        @(posedge ACLK); #1;
        if_req = 1; if_addr = 32'h0000_0808;
        n = 0;
        while (!(sl_active && sl_beat >= 1) && n < 100) begin
            @(posedge ACLK); #1;
            n++;
        end
        chk("rst_reach_rd", (n < 100), 1);
        @(posedge ACLK); #2;
        chk("rst_pre_rready", RREADY_M, 1);
        ARESETn = 0;
        #1;
        chk_reset_outputs("midrst");
        if_req = 0;
        mv = 0;
        repeat (3) @(posedge ACLK);
        #2 ARESETn = 1;
        fetch(32'h0000_0808, 0);
        fetch(32'h0000_0800, 0);

        for (int i = 0; i < 40; i++) begin
            a = 32'h0000_1000 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
            cfg_ar_delay = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4));
            if ($urandom_range(0, 5) == 0) cfg_err_beat = int'($urandom_range(0, 3));
            fetch(a, ($urandom_range(0, 9) == 0));
        end

        repeat (5) @(posedge ACLK);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp_ar_drained", exp_ar.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
